// File: rtl/enc_4x2_pending.sv
// Sticky request encoder: folds request strobes into 2-bit codes,
// draining pending requests highest index first over valid/ready.
module enc_4x2_pending #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          En,
    input  logic [N-1:0]  I,
    output logic [AW-1:0] A,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  pending,
    output logic          overflow
);

    logic          slot_free;
    logic          load;
    logic [AW-1:0] sel;
    logic [N-1:0]  clr;
    logic [N-1:0]  req;
    logic [N-1:0]  pending_next;
    logic          overflow_next;

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            if (pending[k]) begin
                sel = AW'(k);
            end
        end
    end

    always_comb begin
        slot_free = !valid || ready;
        load      = slot_free && (|pending);
        clr       = '0;
        if (load) begin
            clr[sel] = 1'b1;
        end
        req           = En ? I : '0;
        pending_next  = (pending & ~clr) | req;
        overflow_next = |(req & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            A        <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
            if (load) begin
                A     <= sel;
                valid <= 1'b1;
            end else if (slot_free) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
